// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared between the fetch stage and the decode controller.
//   PCSRC_*   : PC-source select encoding driven by the decoder
//   INSTR_W   : instruction word width
//   NOP_WORD  : all-zero instruction word (sll $0,$0,0)
//   fetch_state_t : fetch FSM states
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_J   = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ,   // request outstanding at req_addr, word is wanted
        S_DROP,  // request outstanding at req_addr, word will be discarded
        S_HOLD   // word parked in the skid buffer while IF/ID is stalled
    } fetch_state_t;

endpackage

// File: rtl/pc_redirect_mux.sv
// pc_redirect_mux: priority select of the fetch redirect and its target.
//   stall         in  : decoder outputs are not final, suppress redirect
//   pc_src        in  : decoder PC-source select (11 behaves as sequential)
//   jump_target   in  : j/jal target
//   jr_target     in  : jr register value
//   branch_taken  in  : resolved branch taken
//   branch_target in  : branch target
//   redirect      out : fetch must be redirected this cycle
//   target        out : new fetch address, priority jr > j > branch
module pc_redirect_mux
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              stall,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);

    always_comb begin
        target = branch_target;
        if (pc_src == PCSRC_JR)
            target = jr_target;
        else if (pc_src == PCSRC_J)
            target = jump_target;

        redirect = !stall && ((pc_src == PCSRC_JR) || (pc_src == PCSRC_J) || branch_taken);
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus IF/ID pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   imem_req_o/addr_o : request to variable-latency instruction memory
//   imem_ack_i/rdata_i: memory response, rdata valid with ack
//   stall_i           : hazard unit holds IF/ID and masks redirects
//   pc_src_i, *_target_i, branch_taken_i : redirect sources from decode
//   if_id_valid_o/instr_o/pc4_o : IF/ID register contents
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               stall_i,
    input  logic [1:0]         pc_src_i,
    input  logic [ADDR_W-1:0]  jump_target_i,
    input  logic [ADDR_W-1:0]  jr_target_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               if_id_valid_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0]  if_id_pc4_o
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_addr;
    logic [ADDR_W-1:0]  req_pc4;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc4;
    logic               req_en;
    logic               ack;
    logic               redirect;
    logic [ADDR_W-1:0]  target;

    pc_redirect_mux #(.ADDR_W(ADDR_W)) u_redirect (
        .stall         (stall_i),
        .pc_src        (pc_src_i),
        .jump_target   (jump_target_i),
        .jr_target     (jr_target_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .redirect      (redirect),
        .target        (target)
    );

    // Modulo 2^ADDR_W, so the top word wraps to zero.
    assign req_pc4 = req_addr + ADDR_W'(4);

    // req_en stays low for one cycle after reset: any ack arriving then belongs
    // to a request abandoned by the reset, and gating ack with our own request
    // keeps it from being taken as the answer to the new one.
    assign imem_req_o  = req_en && !rst && (state != S_HOLD);
    assign imem_addr_o = req_addr;
    assign ack         = imem_ack_i && imem_req_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            pc            <= ADDR_W'(RESET_PC);
            req_addr      <= ADDR_W'(RESET_PC);
            skid_instr    <= NOP_WORD;
            skid_pc4      <= '0;
            req_en        <= 1'b0;
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP_WORD;
            if_id_pc4_o   <= '0;
        end else begin
            req_en <= 1'b1;
            case (state)
                S_REQ: begin
                    if (ack) begin
                        if (redirect) begin
                            // Wrong-path word: drop it and refetch at target.
                            pc            <= target;
                            req_addr      <= target;
                            if_id_valid_o <= 1'b0;
                        end else if (stall_i) begin
                            skid_instr <= imem_rdata_i;
                            skid_pc4   <= req_pc4;
                            pc         <= req_pc4;
                            state      <= S_HOLD;
                        end else begin
                            if_id_valid_o <= 1'b1;
                            if_id_instr_o <= imem_rdata_i;
                            if_id_pc4_o   <= req_pc4;
                            pc            <= req_pc4;
                            req_addr      <= req_pc4;
                        end
                    end else if (redirect) begin
                        // The address must stay stable until acked, so the
                        // target waits in pc while the stale word drains.
                        pc            <= target;
                        if_id_valid_o <= 1'b0;
                        state         <= S_DROP;
                    end else if (!stall_i) begin
                        if_id_valid_o <= 1'b0;
                    end
                end
                S_DROP: begin
                    if_id_valid_o <= 1'b0;
                    if (redirect)
                        pc <= target;
                    if (ack) begin
                        req_addr <= redirect ? target : pc;
                        state    <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        if (redirect) begin
                            pc            <= target;
                            req_addr      <= target;
                            if_id_valid_o <= 1'b0;
                        end else begin
                            if_id_valid_o <= 1'b1;
                            if_id_instr_o <= skid_instr;
                            if_id_pc4_o   <= skid_pc4;
                            req_addr      <= pc;
                        end
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A second instance with a
// top-of-memory reset PC and zero-wait memory covers the PC wrap.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] jump_target, jr_target, branch_target;
    logic        branch_taken;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc4;

    logic        req2;
    logic [31:0] addr2, instr2, pc4_2;
    logic        valid2;

    logic        mem_en, force_ack, stall_q;
    int          mem_lat, wait_cnt;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C21_0000;
    endfunction

    fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .stall_i(stall), .pc_src_i(pc_src),
        .jump_target_i(jump_target), .jr_target_i(jr_target),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .if_id_valid_o(if_id_valid), .if_id_instr_o(if_id_instr), .if_id_pc4_o(if_id_pc4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(32)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(req2), .imem_rdata_i(addr2),
        .stall_i(1'b0), .pc_src_i(2'b00),
        .jump_target_i(32'h0), .jr_target_i(32'h0),
        .branch_taken_i(1'b0), .branch_target_i(32'h0),
        .if_id_valid_o(valid2), .if_id_instr_o(instr2), .if_id_pc4_o(pc4_2)
    );

    // Memory: acks after mem_lat cycles of continuous request; force_ack
    // models a stray late ack from a request killed by reset.
    assign imem_ack   = force_ack || (imem_req && mem_en && (wait_cnt >= mem_lat));
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        wait_cnt <= (imem_req && mem_en && !imem_ack) ? wait_cnt + 1 : 0;
        stall_q  <= stall;
    end

    // A valid IF/ID after a non-stalled edge is a newly delivered instruction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if_id_valid && !stall_q) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got pc4=%h instr=%h want none", if_id_pc4, if_id_instr);
            end else begin
                e = sb.pop_front();
                if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_ifid got pc4=%h instr=%h want pc4=%h instr=%h",
                             if_id_pc4, if_id_instr, e.pc4, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr);
        exp_t e;
        e.pc4   = addr + 32'd4;
        e.instr = mem_word(addr);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if ({if_id_valid, if_id_instr, if_id_pc4} !== 65'h0) begin errors++; $display("FAIL rst_ifid got %b %h %h want 0", if_id_valid, if_id_instr, if_id_pc4); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_first_cycle_req got %b want 0", imem_req); end
    endtask

    task automatic test_seq();
        for (int i = 0; i < 8; i++) push(32'(4 * i));
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_addr got %b %h want 1 %h", imem_req, imem_addr, 32'(4 * (i - 1))); end
            if (i >= 2) begin
                checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b want 1", if_id_valid); end
            end
            if (i == 1) begin
                checks++; if (addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %h want fffffffc", addr2); end
            end
            if (i == 2) begin
                checks++; if (addr2 !== 32'h0 || pc4_2 !== 32'h0 || valid2 !== 1'b1) begin errors++; $display("FAIL wrap_second got %h %h %b want 0 0 1", addr2, pc4_2, valid2); end
            end
        end
    endtask

    task automatic test_jump();
        tick();
        pc_src = 2'b01; jump_target = 32'h40;
        push(32'h40);
        tick();
        pc_src = 2'b00;
        checks++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL jump_redirect got %b %h want 0 00000040", if_id_valid, imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL jump_next got %h want 00000044", imem_addr); end
    endtask

    task automatic test_jr_priority();
        pc_src = 2'b10; jr_target = 32'h100;
        branch_taken = 1'b1; branch_target = 32'h200;
        push(32'h100);
        tick();
        pc_src = 2'b00; branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin errors++; $display("FAIL jr_prio got %h %b want 00000100 0", imem_addr, if_id_valid); end
        tick();
        mem_en = 1'b0;
        tick();
    endtask

    task automatic test_latency_drop();
        mem_en = 1'b1; mem_lat = 0; pc_src = 2'b01; jump_target = 32'h10;
        tick();
        pc_src = 2'b00; mem_lat = 3;
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL lat_start got %h want 00000010", imem_addr); end
        tick();
        pc_src = 2'b01; jump_target = 32'h80;
        push(32'h80);
        for (int k = 0; k < 3; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drop_addr got %b %h want 1 00000010", imem_req, imem_addr); end
            tick();
            pc_src = 2'b00;
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin errors++; $display("FAIL drop_target got %h %b want 00000080 0", imem_addr, if_id_valid); end
            tick();
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; mem_lat = 0;
        push(32'h84);
        checks++; if (if_id_pc4 !== 32'h84 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_entry got %h %b want 00000084 1", if_id_pc4, if_id_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b want 0", imem_req); end
            checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h84 || if_id_instr !== mem_word(32'h80)) begin errors++; $display("FAIL stall_stable got %b %h %h want 1 00000084 %h", if_id_valid, if_id_pc4, if_id_instr, mem_word(32'h80)); end
        end
        pc_src = 2'b01; jump_target = 32'h300;
        tick();
        stall = 1'b0; pc_src = 2'b00;
        checks++; if (if_id_pc4 !== 32'h84 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_last got %h %b want 00000084 0", if_id_pc4, imem_req); end
        tick();
        checks++; if (imem_addr !== 32'h88 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_release got %h %b want 00000088 1", imem_addr, imem_req); end
        mem_en = 1'b0;
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL bubble got %b want 0", if_id_valid); end
    endtask

    task automatic test_midop_reset();
        mem_en = 1'b1; mem_lat = 3;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b want 0", imem_req); end
        tick();
        rst = 1'b0; force_ack = 1'b1; mem_lat = 0;
        push(32'h0);
        #1;
        checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL midrst_state got %b %b %h %h want 0 0 0 0", imem_req, if_id_valid, if_id_pc4, if_id_instr); end
        tick();
        force_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL late_ack got %b %h %b want 1 00000000 0", imem_req, imem_addr, if_id_valid); end
        tick();
        mem_en = 1'b0;
    endtask

    task automatic test_drain();
        tick();
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_src = 2'b00;
        jump_target = '0; jr_target = '0; branch_target = '0; branch_taken = 1'b0;
        mem_en = 1'b1; force_ack = 1'b0; mem_lat = 0; wait_cnt = 0; stall_q = 1'b0;
        test_reset();
        test_seq();
        test_jump();
        test_jr_priority();
        test_latency_drop();
        test_stall();
        test_midop_reset();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
